rr_arbiter_16: RTL
==================

Name: rr_arbiter_16

Overview:
16-requester round-robin arbiter that shares a single resource and drives a one-hot 16-bit select, the same encoding our 4-to-16 decoders produce. It registers a 4-bit winner index and decodes it to a one-hot grant. It bounds each grant to a maximum tenure and inserts one turnaround cycle between owners. It sits in front of any shared bus or chip-select group that today is driven directly by a decoder.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles while another requester is pending; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  arbiter enable; low forces all grants off.
req  input  16  request vector; bit i is held high while requester i wants or uses the resource.
grant  output  16  registered one-hot grant, equal to 1 << grant_id when valid, else 0.
grant_id  output  4  index of the current or last owner.
grant_valid  output  1  equals |grant.
busy  output  1  high when state is not IDLE.

Behaviour:
- Reset, synchronous, highest priority, takes effect at the next edge even mid-grant:
  - grant=0, grant_id=0, grant_valid=0, busy=0.
  - state=IDLE, last pointer=15 (so requester 0 has top priority first), hold_cnt=0.
- States are IDLE, GRANT and GAP. All outputs are registered.
- Arbitration runs in IDLE and GAP when enable=1 and req!=0:
  - Winner is the first set req bit scanning upward from (last+1) mod 16, wrapping 15->0.
  - At that edge: grant=1<<winner, grant_id=winner, hold_cnt=1, state=GRANT.
  - Latency is 1 cycle from sampled request to grant.
- IDLE with no request or enable=0: stay in IDLE, grant=0.
- GRANT, evaluated at each edge, first match wins:
  - enable=0: grant=0, last=grant_id, state=IDLE.
  - req[grant_id]=0 (voluntary release): grant=0, last=grant_id, state=GAP.
  - hold_cnt==MAX_HOLD and (req & ~grant)!=0 (forced release): grant=0, last=grant_id, state=GAP. The owner therefore sees exactly MAX_HOLD grant cycles.
  - Otherwise: keep the grant; hold_cnt increments and saturates at MAX_HOLD. A lone requester keeps the grant indefinitely.
- GAP lasts exactly one cycle with grant=0, and arbitration runs at its closing edge.
  - From release to the next grant there is exactly 1 dead cycle.
  - If nothing is pending, or enable=0, GAP goes to IDLE.
- grant_id holds its value after release; it is only meaningful when grant_valid=1.
- A forced-release owner still requesting rejoins the rotation at lowest priority, because last equals that owner.
- A req bit dropping and rising in the same cycle is not visible; the arbiter acts only on sampled levels.
- Invariants:
  - grant has at most one bit set.
  - grant_valid==|grant.
  - grant is never nonzero for a requester whose req was low at the granting edge.

Test Plan:
- Reset, then req=16'h0001 with enable=1 -> after 1 cycle grant=16'h0001, grant_id=0, grant_valid=1, busy=1.
- req=16'h8001 held constant, MAX_HOLD=8:
  - grant=16'h0001 for 8 cycles, then 1 cycle of 0.
  - Then grant=16'h8000 for 8 cycles, then 1 cycle of 0.
  - Then 16'h0001 again.
- Wrap-around: owner 15 releases while req=16'h8004 -> after the gap cycle grant=16'h0004 (scan 0,1,2), not 16'h8000.
- Lone requester 5 held for 20 cycles -> grant=16'h0020 continuous for 20 cycles; hold_cnt saturates at 8, with no gap.
- enable dropped while granted to 3 -> grant=0 the next cycle, busy=0. On re-enable with req=16'h0018, grant goes to 4 (last=3).
- Reset asserted mid-grant to 7 with req=16'h8081 held -> all outputs 0 the next cycle. After reset releases, grant=16'h0001 first (pointer back to 15).

Source files
------------

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16 -- 16-requester round-robin arbiter with bounded tenure.
//
// Shares one resource among 16 requesters and drives a registered one-hot
// grant. The encoding matches a 4-to-16 decoder output. Each owner is held
// for at most MAX_HOLD cycles while anyone else is waiting. One dead cycle
// (GAP) is inserted between consecutive owners.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   enable_i       arbiter enable; low drops any grant and idles
//   req_i[15:0]    request levels, bit i held while requester i wants/uses it
//   grant_o[15:0]  registered one-hot grant (1 << grant_id_o when valid)
//   grant_id_o     index of current or last owner
//   grant_valid_o  |grant_o
//   busy_o         state is GRANT or GAP
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 8  // legal 1..255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [15:0] req_i,
  output logic [15:0] grant_o,
  output logic [3:0]  grant_id_o,
  output logic        grant_valid_o,
  output logic        busy_o
);

  localparam int unsigned NUM_REQ  = 16;
  localparam logic [7:0]  HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e      state_q, state_d;
  logic [15:0] grant_q, grant_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  last_q, last_d;
  logic [7:0]  hold_q, hold_d;

  // Round-robin pick: scan upward from last_q+1. The 4-bit index wraps
  // 15->0 by itself, so k=16 lands back on last_q (lowest priority).
  logic        win_found;
  logic [3:0]  win_id;
  logic [3:0]  scan_idx;
  logic [15:0] win_onehot;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = last_q + 4'(k);
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Decode the winner index to the one-hot select.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_dec
    assign win_onehot[i] = (win_id == 4'(i));
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, GAP: begin
        if (enable_i && win_found) begin
          state_d = GRANT;
          grant_d = win_onehot;
          id_d    = win_id;
          hold_d  = 8'd1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      GRANT: begin
        if (!enable_i) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = id_q;
        end else if (!req_i[id_q]) begin
          state_d = GAP;
          grant_d = '0;
          last_d  = id_q;
        end else if (hold_q == HOLD_MAX && |(req_i & ~grant_q)) begin
          // Tenure exhausted and someone else is waiting.
          state_d = GAP;
          grant_d = '0;
          last_d  = id_q;
        end else if (hold_q != HOLD_MAX) begin
          // Saturates so a lone requester keeps the grant indefinitely.
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= 4'd15;  // requester 0 gets first pick
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = id_q;
  assign grant_valid_o = |grant_q;
  assign busy_o        = (state_q != IDLE);

endmodule
